// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module  : irq_controller
// Brief   : Memory-mapped level/edge interrupt controller feeding CP0 HWInt,
//           with fixed priority and ack/EOI sequencing. Define IRQ_NEST_EN to
//           enable preemption with a 2-deep nesting stack.
// Revision: 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int          NSRC = 6,
    parameter logic [31:0] BASE = 32'h0000_7f40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_src,
    input  logic            irq_ack,
    output logic [NSRC-1:0] HWInt,
    output logic            irq_out
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_latch;
    logic [NSRC-1:0] r_src_d;
    logic [3:0]      r_cur_id;
    logic            r_valid;

    logic            w_cs;
    logic            w_wr;
    logic            w_eoi;
    logic [1:0]      w_idx;
    logic [NSRC-1:0] w_pend;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_edge_next;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_latch_next;
    logic [3:0]      w_top_id;
    logic            w_any;
    logic            w_take;
    logic            w_unused;

    assign w_cs        = (Addr[31:4] == BASE[31:4]);
    assign w_idx       = Addr[3:2];
    assign w_wr        = w_cs & WE;
    assign w_eoi       = w_wr && (w_idx == 2'd3);
    assign w_w1c       = (w_wr && (w_idx == 2'd0)) ? Din[NSRC-1:0] : '0;
    assign w_edge_next = (w_wr && (w_idx == 2'd2)) ? Din[NSRC-1:0] : r_edge;
    assign w_unused    = ^{Addr[1:0], Din};

    // Latched bits only ever exist for edge sources, so OR-ing them in is safe.
    assign w_pend = reset ? (r_latch | (~r_edge & irq_src)) : '0;
    assign w_elig = w_pend & r_mask;
    assign w_any  = |w_elig;

    always_comb begin
        w_top_id = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_top_id = 4'(i);
        end
    end

`ifdef IRQ_NEST_EN
    logic [3:0] r_stk0;
    logic [3:0] r_stk1;
    logic [1:0] r_depth;
    logic       w_preempt;

    assign w_preempt = w_any && (w_top_id < r_cur_id);
    assign w_take    = irq_ack && (((r_state == ST_REQ) && w_any) ||
                       ((r_state == ST_SERVICE) && w_preempt && (r_depth != 2'd2)));
`else
    assign w_take    = irq_ack && (r_state == ST_REQ) && w_any;
`endif

    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ack_clr[i] = w_take && r_edge[i] && (w_top_id == 4'(i));
        end
    end

    // New rising edge wins over W1C/ack clear; masking with the next EDGE value drops stale latches.
    assign w_latch_next = ((r_latch & ~w_w1c & ~w_ack_clr) | (irq_src & ~r_src_d)) & w_edge_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask  <= '0;
            r_edge  <= '0;
            r_latch <= '0;
            r_src_d <= '0;
            HWInt   <= '0;
        end else begin
            if (w_wr && (w_idx == 2'd1)) r_mask <= Din[NSRC-1:0];
            r_edge  <= w_edge_next;
            r_latch <= w_latch_next;
            r_src_d <= irq_src;
            HWInt   <= w_elig;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cur_id <= 4'd0;
            r_valid  <= 1'b0;
            irq_out  <= 1'b0;
`ifdef IRQ_NEST_EN
            r_stk0   <= 4'd0;
            r_stk1   <= 4'd0;
            r_depth  <= 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        irq_out <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!w_any) begin
                        r_state <= ST_IDLE;
                        irq_out <= 1'b0;
                    end else if (w_take) begin
                        r_state  <= ST_SERVICE;
                        r_cur_id <= w_top_id;
                        r_valid  <= 1'b1;
                        irq_out  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
`ifdef IRQ_NEST_EN
                    if (w_take) begin
                        r_stk1   <= r_stk0;
                        r_stk0   <= r_cur_id;
                        r_depth  <= r_depth + 2'd1;
                        r_cur_id <= w_top_id;
                        irq_out  <= 1'b0;
                    end else if (w_eoi) begin
                        irq_out <= 1'b0;
                        if (r_depth == 2'd0) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_cur_id <= r_stk0;
                            r_stk0   <= r_stk1;
                            r_stk1   <= 4'd0;
                            r_depth  <= r_depth - 2'd1;
                        end
                    end else begin
                        irq_out <= w_preempt;
                    end
`else
                    irq_out <= 1'b0;
                    if (w_eoi) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    irq_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        if (w_cs) begin
            case (w_idx)
                2'd0:    Dout[NSRC-1:0] = w_pend;
                2'd1:    Dout[NSRC-1:0] = r_mask;
                2'd2:    Dout[NSRC-1:0] = r_edge;
                default: Dout = {22'd0, r_state, 3'd0, r_valid, r_cur_id};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module  : tb_irq_controller
// Brief   : Directed vector-table bench for irq_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_irq_controller;
    localparam logic [31:0] A_PEND = 32'h0000_7f40;
    localparam logic [31:0] A_MASK = 32'h0000_7f44;
    localparam logic [31:0] A_EDGE = 32'h0000_7f48;
    localparam logic [31:0] A_VEC  = 32'h0000_7f4c;
    localparam logic [31:0] A_OUT  = 32'h0000_7f54;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_src;
    logic        irq_ack;
    logic [5:0]  HWInt;
    logic        irq_out;

    int checks   = 0;
    int failures = 0;

    irq_controller #(.NSRC(6), .BASE(32'h0000_7f40)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
        .irq_src(irq_src), .irq_ack(irq_ack), .HWInt(HWInt), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] din;
        logic [5:0]  src;
        logic        ack;
        logic [31:0] dout;
        logic        irq;
        logic [5:0]  hw;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] addr, input logic we, input logic [31:0] din,
                       input logic [5:0] src, input logic ack,
                       input logic [31:0] dout, input logic irq, input logic [5:0] hw);
        vec_t v;
        v.addr = addr; v.we = we; v.din = din; v.src = src; v.ack = ack;
        v.dout = dout; v.irq = irq; v.hw = hw;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, take the posedge, return 1 ns after it.
    task automatic cyc(input logic [31:0] addr, input logic we, input logic [31:0] din,
                       input logic [5:0] src, input logic ack);
        Addr = addr; WE = we; Din = din; irq_src = src; irq_ack = ack;
        @(posedge clk);
        #1;
        WE = 1'b0; irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Addr = A_VEC; WE = 1'b0; Din = 32'd0; irq_src = 6'd0; irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst irq_out", {31'd0, irq_out}, 32'd0);
        chk("rst HWInt", {26'd0, HWInt}, 32'd0);
        chk("rst VEC", Dout, 32'd0);
        Addr = A_MASK; #0.1;
        chk("rst MASK", Dout, 32'd0);
        reset = 1'b1;

        //   addr    we    din       src    ack   dout           irq   hw
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 0 idle
        add(A_MASK, 1'b1, 32'h3f, 6'h00, 1'b0, 32'h03f, 1'b0, 6'h00); // 1 mask all
        add(A_PEND, 1'b0, 32'h00, 6'h04, 1'b0, 32'h004, 1'b1, 6'h04); // 2 level src2
        add(A_VEC,  1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 3 removed -> idle
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 4
        add(A_EDGE, 1'b1, 32'h01, 6'h00, 1'b0, 32'h001, 1'b0, 6'h00); // 5 src0 edge
        add(A_PEND, 1'b0, 32'h00, 6'h01, 1'b0, 32'h001, 1'b0, 6'h00); // 6 pulse latched
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h001, 1'b1, 6'h01); // 7 stays set
        add(A_PEND, 1'b1, 32'h01, 6'h00, 1'b0, 32'h000, 1'b1, 6'h01); // 8 W1C
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 9 req drops
        add(A_PEND, 1'b1, 32'h01, 6'h01, 1'b0, 32'h001, 1'b0, 6'h00); // 10 set wins
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h001, 1'b1, 6'h01); // 11
        add(A_VEC,  1'b0, 32'h00, 6'h00, 1'b1, 32'h210, 1'b0, 6'h01); // 12 ack id0
        add(A_PEND, 1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 13 ack cleared edge
        add(A_VEC,  1'b1, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 14 EOI
        add(A_EDGE, 1'b1, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 15 all level
        add(A_PEND, 1'b0, 32'h00, 6'h12, 1'b0, 32'h012, 1'b1, 6'h12); // 16 src1+src4
        add(A_VEC,  1'b0, 32'h00, 6'h12, 1'b1, 32'h211, 1'b0, 6'h12); // 17 ack -> id1
        add(A_VEC,  1'b0, 32'h00, 6'h12, 1'b0, 32'h211, 1'b0, 6'h12); // 18
        add(A_VEC,  1'b1, 32'h00, 6'h12, 1'b0, 32'h001, 1'b0, 6'h12); // 19 EOI -> idle
        add(A_VEC,  1'b0, 32'h00, 6'h12, 1'b0, 32'h101, 1'b1, 6'h12); // 20 re-request
        add(A_VEC,  1'b1, 32'h00, 6'h12, 1'b0, 32'h101, 1'b1, 6'h12); // 21 EOI ignored
        add(A_MASK, 1'b1, 32'h00, 6'h3f, 1'b0, 32'h000, 1'b1, 6'h3f); // 22 mask off
        add(A_PEND, 1'b0, 32'h00, 6'h3f, 1'b0, 32'h03f, 1'b0, 6'h00); // 23 masked
        add(A_VEC,  1'b0, 32'h00, 6'h3f, 1'b1, 32'h001, 1'b0, 6'h00); // 24 ack ignored
        add(A_VEC,  1'b0, 32'h00, 6'h3f, 1'b0, 32'h001, 1'b0, 6'h00); // 25
        add(A_OUT,  1'b1, 32'h3f, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 26 outside window
        add(A_MASK, 1'b0, 32'h00, 6'h00, 1'b0, 32'h000, 1'b0, 6'h00); // 27 mask untouched

        foreach (vq[i]) begin
            cyc(vq[i].addr, vq[i].we, vq[i].din, vq[i].src, vq[i].ack);
            chk($sformatf("v%0d Dout", i), Dout, vq[i].dout);
            chk($sformatf("v%0d irq_out", i), {31'd0, irq_out}, {31'd0, vq[i].irq});
            chk($sformatf("v%0d HWInt", i), {26'd0, HWInt}, {26'd0, vq[i].hw});
        end

        // Service src4, then raise higher-priority src1.
        cyc(A_MASK, 1'b1, 32'h3f, 6'h10, 1'b0);
        cyc(A_VEC, 1'b0, 32'h00, 6'h10, 1'b0);
        chk("n req irq_out", {31'd0, irq_out}, 32'd1);
        cyc(A_VEC, 1'b0, 32'h00, 6'h10, 1'b1);
        chk("n ack VEC", Dout, 32'h214);
        chk("n ack irq_out", {31'd0, irq_out}, 32'd0);
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b0);
`ifdef IRQ_NEST_EN
        chk("n preempt irq_out", {31'd0, irq_out}, 32'd1);
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b0);
        chk("n preempt hold", {31'd0, irq_out}, 32'd1);
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b1);
        chk("n nest VEC", Dout, 32'h211);
        chk("n nest irq_out", {31'd0, irq_out}, 32'd0);
        cyc(A_VEC, 1'b1, 32'h00, 6'h12, 1'b0);
        chk("n pop VEC", Dout, 32'h214);
        cyc(A_VEC, 1'b1, 32'h00, 6'h12, 1'b0);
        chk("n eoi VEC", Dout, 32'h004);
`else
        chk("n no preempt", {31'd0, irq_out}, 32'd0);
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b0);
        chk("n no preempt hold", {31'd0, irq_out}, 32'd0);
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b1);
        chk("n ack ignored VEC", Dout, 32'h214);
        chk("n ack ignored irq", {31'd0, irq_out}, 32'd0);
        cyc(A_VEC, 1'b1, 32'h00, 6'h12, 1'b0);
        chk("n eoi VEC", Dout, 32'h004);
`endif
        cyc(A_VEC, 1'b0, 32'h00, 6'h12, 1'b0);
        chk("n rereq VEC", Dout, 32'h104);
        chk("n rereq irq_out", {31'd0, irq_out}, 32'd1);
        chk("n rereq HWInt", {26'd0, HWInt}, 32'h12);

        // Asynchronous reset between clock edges with sources still active.
        #2;
        reset = 1'b0;
        #0.1;
        chk("arst irq_out", {31'd0, irq_out}, 32'd0);
        chk("arst HWInt", {26'd0, HWInt}, 32'd0);
        chk("arst VEC", Dout, 32'd0);
        Addr = A_PEND; #0.1;
        chk("arst PEND", Dout, 32'd0);
        Addr = A_MASK; #0.1;
        chk("arst MASK", Dout, 32'd0);
        Addr = A_EDGE; #0.1;
        chk("arst EDGE", Dout, 32'd0);
        #5;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt lines (switch, timer, UART, ...) and CP0's HWInt inputs.
- Qualifies each source as level or edge, latches edge events, applies masks and fixed priority, and sequences request/acknowledge/end-of-interrupt with the CPU.
- Sits on the same peripheral bus as the other drivers, decoded at BASE.

Parameters:
NSRC, 6, number of interrupt sources; maps to HWInt[7:2]; legal range 1..8
BASE, 32'h0000_7f40, word-aligned base address of the 16-byte register window

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
Addr  input  32  CPU byte address
WE  input  1  write enable, qualified internally by chip select
Din  input  32  write data
Dout  output  32  read data; combinational from Addr; 0 when not selected
irq_src  input  NSRC  raw interrupt lines, synchronous to clk
irq_ack  input  1  one-cycle pulse from CP0 when the exception is taken
HWInt  output  NSRC  PEND & MASK, registered, to CP0
irq_out  output  1  registered request to CP0

Behaviour:
- Chip select: CS = (Addr[31:4] == BASE[31:4]). Register index = Addr[3:2]. Write occurs when CS & WE at the posedge.
- Register 0x0, PEND: read-only for level bits. Edge bits are write-1-to-clear.
- Register 0x4, MASK: read/write, bits [NSRC-1:0]; 1 = enabled.
- Register 0x8, EDGE: read/write; 1 = rising-edge source, 0 = level source.
- Register 0xC, VEC: read returns {state[1:0] at [9:8], valid at [4], cur_id[3:0]}. Any write is EOI.
- Unused bits read 0.
- Level source: PEND bit equals the current irq_src bit. It is not latched.
- Edge source: a delayed copy src_d is kept. The bit sets on irq_src & ~src_d and stays set until it is W1C-cleared or acknowledged. If set and clear occur in the same cycle, set wins.
- Clearing EDGE to 0 drops the latched bit; the PEND bit then follows the level.
- Eligible = PEND & MASK. Priority is fixed: the lowest index is highest. top_id is the lowest set index of eligible.
- State machine:
  - IDLE -> REQ when eligible != 0. irq_out goes high one cycle after eligible becomes nonzero.
  - REQ -> SERVICE on irq_ack:
    - cur_id <= top_id and valid <= 1.
    - If cur_id is an edge source, its PEND bit is cleared. Set-wins still applies for a new edge in the same cycle.
    - irq_out goes low the next cycle.
  - REQ -> IDLE if eligible falls to 0 before irq_ack (level source removed or masked). irq_out drops the next cycle.
  - SERVICE -> IDLE on an EOI write; valid <= 0. If eligible is still nonzero, IDLE moves to REQ on the following cycle.
  - irq_ack outside REQ is ignored.
  - An EOI write outside SERVICE is ignored.
- HWInt is registered every cycle as PEND & MASK, independent of state.
- Reset values: all registers 0, src_d = 0, state IDLE, cur_id 0, valid 0, irq_out 0, HWInt 0.
- reset asserted at any time, including mid-SERVICE, immediately clears everything asynchronously.
- Writes outside the window have no effect. Reads outside the window return Dout = 0.

Optional Feature:
- Macro: IRQ_NEST_EN.
- Defined:
  - In SERVICE, if top_id < cur_id, irq_out is raised (preemption).
  - A second irq_ack pushes cur_id onto a 2-deep stack and loads the new top_id.
  - EOI pops the stack. The state returns to IDLE only when the stack is empty.
  - An ack when the stack is full is ignored.
- Undefined: irq_out stays 0 throughout SERVICE, and no stack exists.

Test Plan:
- Reset low mid-run -> Dout(0x0/0x4/0x8) = 0, irq_out = 0, HWInt = 0, VEC state = 0, immediately and without waiting for a clock edge.
- MASK = 0x3F, EDGE = 0, irq_src = 6'h04 -> PEND reads 0x04; HWInt = 0x04 and irq_out = 1 one cycle later. irq_src -> 0 before ack -> irq_out = 0 next cycle, state IDLE.
- EDGE = 0x01, one-cycle pulse on src0 -> PEND bit0 stays 1. Write PEND = 0x01 -> bit0 = 0. Repeat the write in the same cycle as a new edge -> bit0 stays 1.
- irq_src = 6'h12 level, MASK = 0x3F, irq_ack -> VEC = {state SERVICE, valid 1, cur_id 1}, irq_out = 0. EOI -> IDLE, then REQ, irq_out = 1 two cycles after the EOI write.
- MASK = 0x00 with irq_src = 0x3F -> irq_out stays 0 and HWInt = 0. irq_ack pulse in IDLE -> no state change.
- IRQ_NEST_EN: SERVICE with cur_id = 4, assert src1 -> irq_out = 1; ack -> cur_id = 1; EOI -> cur_id = 4, still SERVICE; EOI -> IDLE. Without the macro, irq_out stays 0 after src1 is asserted.
